// File: rtl/vp_last_value_table.sv
// Last-value predictor: direct-mapped tagged table with per-entry saturating
// confidence, two registered lookup lanes and a sequential invalidate walker.

`ifndef P_CONF_WIDTH
`define P_CONF_WIDTH 2
`endif

package vp_lvt_pkg;
    localparam int CONF_W = `P_CONF_WIDTH;

    typedef struct packed {
        logic              valid;
        logic              misp;
        logic [31:0]       pc;
        logic [31:0]       actual;
        logic [CONF_W-1:0] conf;
    } vp_fb_pkt_t;

    typedef struct packed {
        logic              i0_valid;
        logic              i0_used;
        logic [31:1]       i0_pc;
        logic [31:0]       i0_result;
        logic [CONF_W-1:0] i0_conf;
        logic              i1_valid;
        logic              i1_used;
        logic [31:1]       i1_pc;
        logic [31:0]       i1_result;
        logic [CONF_W-1:0] i1_conf;
    } vp_fw_pkt_t;
endpackage

// One lookup lane: qualifies the indexed entry against the request tag.
module vp_lvt_lane #(
    parameter int TAG_W       = 8,
    parameter int CONF_W      = 2,
    parameter int CONF_THRESH = 3
) (
    input  logic              lookup_valid,
    input  logic              busy,
    input  logic [TAG_W-1:0]  lookup_tag,
    input  logic              ent_valid,
    input  logic [TAG_W-1:0]  ent_tag,
    input  logic [31:0]       ent_value,
    input  logic [CONF_W-1:0] ent_conf,
    output logic              hit,
    output logic              used,
    output logic [31:0]       result,
    output logic [CONF_W-1:0] conf
);
    localparam logic [CONF_W:0] THRESH = CONF_THRESH[CONF_W:0];

    always_comb begin
        hit    = lookup_valid & ent_valid & (ent_tag == lookup_tag) & ~busy;
        used   = hit & ({1'b0, ent_conf} >= THRESH);
        result = hit ? ent_value : '0;
        conf   = hit ? ent_conf  : '0;
    end
endmodule

module vp_last_value_table
    import vp_lvt_pkg::*;
#(
    parameter int ENTRIES     = 64,
    parameter int TAG_W       = 8,
    parameter int CONF_THRESH = 2**`P_CONF_WIDTH - 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i0_lookup_valid,
    input  logic [31:1] i0_lookup_pc,
    input  logic       i1_lookup_valid,
    input  logic [31:1] i1_lookup_pc,
    input  vp_fb_pkt_t vp_fb_pkt,
    input  logic       vp_flush,
    output vp_fw_pkt_t vp_fw_pkt,
    output logic       init_busy
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CONF_W-1:0] CONF_MAX = '1;

    typedef enum logic {WALK, IDLE} state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               ptr_q, ptr_d;
    logic                           init_busy_q;
    vp_fw_pkt_t                     fw_q, fw_d;

    logic [ENTRIES-1:0]             valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [ENTRIES-1:0][31:0]       value_q, value_d;
    logic [ENTRIES-1:0][CONF_W-1:0] conf_q, conf_d;

    logic                           busy;
    logic [IDX_W-1:0]               fb_idx;
    logic [TAG_W-1:0]               fb_tag;
    logic                           fb_hit;

    assign busy = (state_q == WALK);

    // Walker: flush always restarts from entry 0, even mid-walk.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (vp_flush) begin
            state_d = WALK;
            ptr_d   = '0;
        end else if (state_q == WALK) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == IDX_W'(ENTRIES - 1)) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WALK;
            ptr_q       <= '0;
            init_busy_q <= 1'b1;
            fw_q        <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_busy_q <= (state_d == WALK);
            fw_q        <= fw_d;
        end
    end

    // Table training; feedback arriving while the walker runs is dropped.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        value_d = value_q;
        conf_d  = conf_q;
        fb_idx  = vp_fb_pkt.pc[IDX_W:1];
        fb_tag  = vp_fb_pkt.pc[IDX_W+TAG_W:IDX_W+1];
        fb_hit  = valid_q[fb_idx] && (tag_q[fb_idx] == fb_tag);
        if (state_q == WALK) begin
            valid_d[ptr_q] = 1'b0;
            conf_d[ptr_q]  = '0;
        end else if (vp_fb_pkt.valid) begin
            if (!fb_hit) begin
                valid_d[fb_idx] = 1'b1;
                tag_d[fb_idx]   = fb_tag;
                value_d[fb_idx] = vp_fb_pkt.actual;
                conf_d[fb_idx]  = '0;
            end else if (vp_fb_pkt.misp || (vp_fb_pkt.actual != value_q[fb_idx])) begin
                value_d[fb_idx] = vp_fb_pkt.actual;
                conf_d[fb_idx]  = '0;
            end else if (conf_q[fb_idx] != CONF_MAX) begin
                conf_d[fb_idx] = conf_q[fb_idx] + 1'b1;
            end
        end
    end

    // Storage carries no reset; the walker is what invalidates it.
    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        tag_q   <= tag_d;
        value_q <= value_d;
        conf_q  <= conf_d;
    end

    logic [1:0]             lk_valid;
    logic [1:0][31:1]       lk_pc;
    logic [1:0][IDX_W-1:0]  lk_idx;
    logic [1:0][TAG_W-1:0]  lk_tag;
    logic [1:0]             ln_hit, ln_used;
    logic [1:0][31:0]       ln_result;
    logic [1:0][CONF_W-1:0] ln_conf;

    assign lk_valid = {i1_lookup_valid, i0_lookup_valid};
    assign lk_pc    = {i1_lookup_pc, i0_lookup_pc};

    for (genvar g = 0; g < 2; g++) begin : g_lane
        assign lk_idx[g] = lk_pc[g][IDX_W:1];
        assign lk_tag[g] = lk_pc[g][IDX_W+TAG_W:IDX_W+1];

        vp_lvt_lane #(
            .TAG_W      (TAG_W),
            .CONF_W     (CONF_W),
            .CONF_THRESH(CONF_THRESH)
        ) u_lane (
            .lookup_valid(lk_valid[g]),
            .busy        (busy),
            .lookup_tag  (lk_tag[g]),
            .ent_valid   (valid_q[lk_idx[g]]),
            .ent_tag     (tag_q[lk_idx[g]]),
            .ent_value   (value_q[lk_idx[g]]),
            .ent_conf    (conf_q[lk_idx[g]]),
            .hit         (ln_hit[g]),
            .used        (ln_used[g]),
            .result      (ln_result[g]),
            .conf        (ln_conf[g])
        );
    end

    // Lookups read pre-update storage, so same-cycle training is not bypassed.
    always_comb begin
        fw_d           = '0;
        fw_d.i0_valid  = ln_hit[0];
        fw_d.i0_used   = ln_used[0];
        fw_d.i0_pc     = i0_lookup_pc;
        fw_d.i0_result = ln_result[0];
        fw_d.i0_conf   = ln_conf[0];
        fw_d.i1_valid  = ln_hit[1];
        fw_d.i1_used   = ln_used[1];
        fw_d.i1_pc     = i1_lookup_pc;
        fw_d.i1_result = ln_result[1];
        fw_d.i1_conf   = ln_conf[1];
    end

    logic unused_fb_bits;
    assign unused_fb_bits = ^{vp_fb_pkt.conf, vp_fb_pkt.pc[31:IDX_W+TAG_W+1], vp_fb_pkt.pc[0]};

    assign vp_fw_pkt = fw_q;
    assign init_busy = init_busy_q;
endmodule

// File: tb/tb_vp_last_value_table.sv
// Bench for vp_last_value_table: directed vector table, reset/flush walk
// sequences and a randomized run against an array-based reference model.

`ifndef P_CONF_WIDTH
`define P_CONF_WIDTH 2
`endif

module tb_vp_last_value_table;
    import vp_lvt_pkg::*;

    localparam int N    = 64;
    localparam int CMAX = 2**`P_CONF_WIDTH - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        i0_lookup_valid, i1_lookup_valid;
    logic [31:1] i0_lookup_pc, i1_lookup_pc;
    vp_fb_pkt_t  vp_fb_pkt;
    logic        vp_flush;
    vp_fw_pkt_t  vp_fw_pkt;
    logic        init_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vp_last_value_table dut (
        .clk            (clk),
        .rst            (rst),
        .i0_lookup_valid(i0_lookup_valid),
        .i0_lookup_pc   (i0_lookup_pc),
        .i1_lookup_valid(i1_lookup_valid),
        .i1_lookup_pc   (i1_lookup_pc),
        .vp_fb_pkt      (vp_fb_pkt),
        .vp_flush       (vp_flush),
        .vp_fw_pkt      (vp_fw_pkt),
        .init_busy      (init_busy)
    );

    typedef struct {
        bit          rst, flush, fbv, misp;
        logic [31:0] fpc, fact;
        bit          l0v, l1v;
        logic [31:0] l0pc, l1pc;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          e0v, e0u, e1v, e1u;
        logic [31:0] e0r, e1r;
        logic [1:0]  e0c, e1c;
    } vec_t;

    // Reference model: a walk is modelled as an instant clear plus a busy
    // window; lookups are masked and feedback dropped throughout the window.
    bit          m_valid [N];
    int          m_tag   [N];
    logic [31:0] m_val   [N];
    int          m_conf  [N];
    int          busy_left = 0;

    function automatic int pidx(logic [31:0] pc); return (pc / 2) % N;   endfunction
    function automatic int ptag(logic [31:0] pc); return (pc / 128) % 256; endfunction

    function automatic void look(input bit v, input logic [31:0] pc, output bit hv,
                                 output bit hu, output logic [31:0] r, output logic [1:0] c);
        int i = pidx(pc);
        hv = v && busy_left == 0 && m_valid[i] && m_tag[i] == ptag(pc);
        hu = hv && m_conf[i] >= CMAX;
        r  = hv ? m_val[i] : 32'd0;
        c  = hv ? m_conf[i][1:0] : 2'd0;
    endfunction

    function automatic vp_fw_pkt_t model_out(stim_t s);
        vp_fw_pkt_t p = '0;
        if (s.rst) return p;
        p.i0_pc = s.l0pc[31:1];
        p.i1_pc = s.l1pc[31:1];
        look(s.l0v, s.l0pc, p.i0_valid, p.i0_used, p.i0_result, p.i0_conf);
        look(s.l1v, s.l1pc, p.i1_valid, p.i1_used, p.i1_result, p.i1_conf);
        return p;
    endfunction

    function automatic void model_step(stim_t s);
        int i = pidx(s.fpc);
        if (s.rst || s.flush) begin
            foreach (m_valid[k]) m_valid[k] = 1'b0;
            busy_left = N;
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (s.fbv) begin
            if (m_valid[i] && m_tag[i] == ptag(s.fpc)) begin
                if (s.fact == m_val[i] && !s.misp) m_conf[i] = (m_conf[i] < CMAX) ? m_conf[i] + 1 : CMAX;
                else begin m_val[i] = s.fact; m_conf[i] = 0; end
            end else begin
                m_valid[i] = 1'b1; m_tag[i] = ptag(s.fpc); m_val[i] = s.fact; m_conf[i] = 0;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic stim_t nop();
        stim_t s = '{default: 0};
        return s;
    endfunction

    // Applies one cycle of stimulus and compares the whole output against the model.
    task automatic tick(input stim_t s);
        vp_fw_pkt_t e;
        bit         eb;
        rst              = s.rst;
        vp_flush         = s.flush;
        vp_fb_pkt.valid  = s.fbv;
        vp_fb_pkt.misp   = s.misp;
        vp_fb_pkt.pc     = s.fpc;
        vp_fb_pkt.actual = s.fact;
        vp_fb_pkt.conf   = CONF_W'($urandom);
        i0_lookup_valid  = s.l0v;
        i0_lookup_pc     = s.l0pc[31:1];
        i1_lookup_valid  = s.l1v;
        i1_lookup_pc     = s.l1pc[31:1];
        e = model_out(s);
        model_step(s);
        eb = (busy_left > 0);
        @(posedge clk); #1;
        chk("fw_pkt", 160'(vp_fw_pkt), 160'(e));
        chk("init_busy", 160'(init_busy), 160'(eb));
    endtask

    function automatic vec_t mk(bit fbv, bit misp, logic [31:0] fpc, logic [31:0] fact,
                                bit l0v, logic [31:0] l0pc, bit l1v, logic [31:0] l1pc,
                                bit e0v, bit e0u, logic [31:0] e0r, logic [1:0] e0c,
                                bit e1v, bit e1u, logic [31:0] e1r, logic [1:0] e1c);
        vec_t v;
        v.s = nop();
        v.s.fbv = fbv; v.s.misp = misp; v.s.fpc = fpc; v.s.fact = fact;
        v.s.l0v = l0v; v.s.l0pc = l0pc; v.s.l1v = l1v; v.s.l1pc = l1pc;
        v.e0v = e0v; v.e0u = e0u; v.e0r = e0r; v.e0c = e0c;
        v.e1v = e1v; v.e1u = e1u; v.e1r = e1r; v.e1c = e1c;
        return v;
    endfunction

    function automatic logic [31:0] rnd_pc();
        logic [31:0] idx_pool[4] = '{0, 1, 2, 63};
        logic [31:0] tag_pool[3] = '{32'h20, 32'h21, 32'h7f};
        return (tag_pool[$urandom_range(0, 2)] << 7) | (idx_pool[$urandom_range(0, 3)] << 1)
               | 32'($urandom_range(0, 1));
    endfunction

    localparam logic [31:0] W = 32'h1000;
    localparam logic [31:0] A = 32'h1080;

    initial begin
        vec_t  vt[$];
        stim_t s;
        int    n;

        vt.push_back(mk(1,0,W,32'hDEADBEEF, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        vt.push_back(mk(0,0,0,0, 1,W,0,0, 1,0,32'hDEADBEEF,0, 0,0,0,0));
        vt.push_back(mk(1,0,W,32'hDEADBEEF, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        vt.push_back(mk(1,0,W,32'hDEADBEEF, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        vt.push_back(mk(1,0,W,32'hDEADBEEF, 1,W,0,0, 1,0,32'hDEADBEEF,2, 0,0,0,0));
        vt.push_back(mk(0,0,0,0, 1,W,1,W, 1,1,32'hDEADBEEF,3, 1,1,32'hDEADBEEF,3));
        vt.push_back(mk(1,0,W,32'hDEADBEEF, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        vt.push_back(mk(0,0,0,0, 0,0,1,W, 0,0,0,0, 1,1,32'hDEADBEEF,3));
        vt.push_back(mk(1,1,W,32'hDEADBEEF, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        vt.push_back(mk(0,0,0,0, 1,W,0,0, 1,0,32'hDEADBEEF,0, 0,0,0,0));
        vt.push_back(mk(1,0,W,32'h1234, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        vt.push_back(mk(0,0,0,0, 1,W,0,0, 1,0,32'h1234,0, 0,0,0,0));
        vt.push_back(mk(1,0,A,32'h55, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        vt.push_back(mk(0,0,0,0, 1,W,1,A, 0,0,0,0, 1,0,32'h55,0));
        vt.push_back(mk(1,0,W,32'h1234, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        vt.push_back(mk(1,0,W,32'h99, 1,W,1,W, 1,0,32'h1234,0, 1,0,32'h1234,0));
        vt.push_back(mk(0,0,0,0, 1,W,1,W, 1,0,32'h99,0, 1,0,32'h99,0));

        // Reset: two cycles of rst, then the busy window must be exactly N samples.
        s = nop(); s.rst = 1;
        tick(s); tick(s);
        chk("reset_fw_zero", 160'(vp_fw_pkt), 160'(0));
        chk("reset_busy", 160'(init_busy), 160'(1));
        n = 1;
        while (init_busy && n < 200) begin
            s = nop(); s.l0v = 1; s.l0pc = rnd_pc(); s.l1v = 1; s.l1pc = rnd_pc();
            s.fbv = 1; s.fpc = s.l0pc; s.fact = $urandom;
            tick(s);
            if (init_busy) n++;
        end
        chk("reset_busy_len", 160'(n), 160'(N));

        foreach (vt[k]) begin
            tick(vt[k].s);
            chk($sformatf("vec%0d", k),
                160'({vp_fw_pkt.i0_valid, vp_fw_pkt.i0_used, vp_fw_pkt.i0_result, vp_fw_pkt.i0_conf,
                      vp_fw_pkt.i1_valid, vp_fw_pkt.i1_used, vp_fw_pkt.i1_result, vp_fw_pkt.i1_conf}),
                160'({vt[k].e0v, vt[k].e0u, vt[k].e0r, vt[k].e0c,
                      vt[k].e1v, vt[k].e1u, vt[k].e1r, vt[k].e1c}));
        end

        // Flush, then flush again 10 cycles into the walk; feedback inside is dropped.
        s = nop(); s.flush = 1;
        tick(s);
        for (int k = 0; k < 9; k++) tick(nop());
        tick(s);
        n = 1;
        while (init_busy && n < 200) begin
            s = nop(); s.fbv = 1; s.fpc = W; s.fact = 32'h77;
            tick(s);
            if (init_busy) n++;
        end
        chk("flush_busy_len", 160'(n), 160'(N));
        s = nop(); s.l0v = 1; s.l0pc = W; s.l1v = 1; s.l1pc = A;
        tick(s);
        chk("flush_miss_i0", 160'(vp_fw_pkt.i0_valid), 160'(0));
        chk("flush_miss_i1", 160'(vp_fw_pkt.i1_valid), 160'(0));

        // Randomized traffic over a small PC/value pool so hits, aliases and saturation occur.
        for (int k = 0; k < 3000; k++) begin
            s = nop();
            s.rst   = ($urandom_range(0, 1499) == 0);
            s.flush = ($urandom_range(0, 399) == 0);
            s.fbv   = ($urandom_range(0, 2) != 0);
            s.misp  = ($urandom_range(0, 7) == 0);
            s.fpc   = rnd_pc();
            s.fact  = 32'($urandom_range(1, 3));
            s.l0v   = ($urandom_range(0, 3) != 0);
            s.l0pc  = rnd_pc();
            s.l1v   = ($urandom_range(0, 3) != 0);
            s.l1pc  = ($urandom_range(0, 3) == 0) ? s.l0pc : rnd_pc();
            tick(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vp_last_value_table.md
Name: vp_last_value_table

Overview:
- Last-value predictor table for the value-prediction (VP) path.
- Serves two lookups per cycle (i0/i1) from decode and returns one registered vp_fw_pkt_t carrying the predicted results.
- Trains from the single vp_fb_pkt_t feedback stream that execute/commit produces.
- Direct-mapped, tagged, one saturating confidence counter per entry (`P_CONF_WIDTH bits), with an invalidate walker for reset and flush.

Parameters:
- ENTRIES, 64, table depth; power of 2, ≥4. IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry.
- CONF_THRESH, 2**`P_CONF_WIDTH-1, minimum confidence at which a prediction is marked used.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- i0_lookup_valid  in  1  i0 lookup request
- i0_lookup_pc  in  [31:1]  i0 instruction PC
- i1_lookup_valid  in  1  i1 lookup request
- i1_lookup_pc  in  [31:1]  i1 instruction PC
- vp_fb_pkt  in  vp_fb_pkt_t  training feedback (misp, actual, pc, conf, valid)
- vp_flush  in  1  invalidate whole table
- vp_fw_pkt  out  vp_fw_pkt_t  registered predictions for i0/i1
- init_busy  out  1  invalidate walk in progress

Behaviour:
- Reset/clock: one clock; reset is synchronous, active-high (clk, rst).
- Index/tag: index = pc[IDX_W:1]; tag = pc[IDX_W+TAG_W:IDX_W+1]. Feedback uses the same bit positions of vp_fb_pkt.pc[31:0].
- Entry state: {valid, tag, value[31:0], conf}. Storage is not reset; only valid and conf are cleared, by the walker.
- FSM states: WALK, IDLE.
  - rst (any cycle, including mid-walk) → WALK, ptr=0.
  - In WALK: each cycle clears valid/conf of entry ptr, then ptr++. After entry ENTRIES-1 → IDLE.
  - vp_flush in IDLE → WALK, ptr=0. vp_flush in WALK restarts at ptr=0.
  - A walk therefore lasts exactly ENTRIES cycles after the rst/flush cycle.
- init_busy = (state==WALK), registered. Reset value 1.
- Lookup:
  - Latency 1: request at cycle N → vp_fw_pkt fields at N+1.
  - iX_valid = lookup_valid & entry.valid & tag match & ~busy.
  - iX_used = iX_valid & (conf ≥ CONF_THRESH).
  - iX_pc = lookup pc echo (registered).
  - iX_result and iX_conf = entry contents when iX_valid, else 0.
  - i0 and i1 may hit the same index in the same cycle; both get identical data.
- Feedback (vp_fb_pkt.valid, state IDLE), written at end of cycle:
  - Hit, actual == value, misp=0 → conf = min(conf+1, 2**`P_CONF_WIDTH-1).
  - Hit, actual == value, misp=1 → conf = 0, value kept.
  - Hit, actual != value → value = actual, conf = 0.
  - Miss (invalid or tag mismatch) → allocate: valid=1, tag, value=actual, conf=0. Replaces any aliasing entry.
  - vp_fb_pkt.conf is debug only and ignored.
  - Feedback during WALK is dropped.
- Same-cycle feedback and lookup to the same index → lookup returns pre-update contents (no bypass).
- Reset values: vp_fw_pkt = all zeros; init_busy = 1.
- Lookups during WALK → valid=0, used=0, result=0, conf=0; pc is still echoed.

Test Plan (ENTRIES=64, TAG_W=8, `P_CONF_WIDTH=2, CONF_THRESH=3):
1. Reset/walk: rst high 2 cycles, then low → vp_fw_pkt all 0. init_busy stays 1 for exactly 64 cycles after rst deasserts, then 0. Lookups issued during that window return valid=0.
2. Allocate/hit: fb valid, pc=0x1000, actual=0xDEADBEEF; next cycle lookup i0 pc=0x1000 → following cycle i0_valid=1, i0_result=0xDEADBEEF, i0_conf=0, i0_used=0.
3. Train and saturate: three more matching fb to 0x1000 → conf=3, i0_used=1. A fourth match keeps conf=3. A matching fb with misp=1 → conf=0, result unchanged.
4. Value change and alias: fb pc=0x1000 actual=0x1234 → conf=0, result=0x1234. fb pc=0x1080 (same index, different tag) actual=0x55 → lookup 0x1000 valid=0, lookup 0x1080 valid=1 result=0x55.
5. Collision and dual port: same cycle fb 0x1000 actual=0x99 plus lookup i0 and i1 both pc=0x1000 → both return the old value. A lookup on the next cycle returns 0x99.
6. Flush mid-walk: vp_flush in IDLE, then again 10 cycles later → init_busy=1 for 64 cycles after the second flush. Feedback sent during the walk is dropped. After the walk, all previously trained PCs miss.
